au_add_vz_serial: RTL and testbench



---
 rtl/au_add_vz_serial.sv | 182 ++++++++++++++++++
 tb/tb_au_add_vz_serial.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/au_add_vz_serial.sv
// Digit-serial adder a+b+ci with carry, signed-overflow and zero flags.
// Optional saturation enabled by defining AU_ADD_VZ_SERIAL_SAT_EN.
module au_add_vz_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef AU_ADD_VZ_SERIAL_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             v,
  output logic             z
);

  localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("au_add_vz_serial: DIGIT must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
`ifdef AU_ADD_VZ_SERIAL_SAT_EN
  logic             sat_q, sat_d;
`endif

  logic [DIGIT:0]   dfull;
  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic [WIDTH-1:0] dsum_w;
  logic [WIDTH-1:0] sum_w;
  logic             last;
  logic             cmsb;
  logic             ovf;
  logic             zfin;
  logic             accept;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    s_d     = s_q;
    co_d    = co_q;
    v_d     = v_q;
    z_d     = z_q;
`ifdef AU_ADD_VZ_SERIAL_SAT_EN
    sat_d   = sat_q;
`endif

    dfull  = {1'b0, a_q[DIGIT-1:0]}
           + {1'b0, b_q[DIGIT-1:0]}
           + (DIGIT+1)'(carry_q);
    dsum   = dfull[DIGIT-1:0];
    dco    = dfull[DIGIT];
    dsum_w = '0;
    dsum_w[DIGIT-1:0] = dsum;
    sum_w  = (acc_q >> DIGIT) | (dsum_w << (WIDTH - DIGIT));
    last   = (cnt_q == CW'(N - 1));
    // carry into the MSB recovered from the MSB's own sum bit
    cmsb   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
    ovf    = cmsb ^ dco;
    zfin   = zacc_q & (dsum == '0);

    in_ready  = (state_q == IDLE)
              | ((state_q == DONE) & out_ready);
    out_valid = (state_q == DONE);
    accept    = in_valid & in_ready;

    unique case (state_q)
      IDLE: ;
      CALC: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = sum_w;
        carry_d = dco;
        zacc_d  = zfin;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          s_d     = sum_w;
          co_d    = dco;
          v_d     = ovf;
          z_d     = zfin;
`ifdef AU_ADD_VZ_SERIAL_SAT_EN
          // a_q[DIGIT-1] is the original sign bit of a here
          if (sat_q & ovf) begin
            s_d = {a_q[DIGIT-1], {(WIDTH-1){~a_q[DIGIT-1]}}};
            z_d = 1'b0;
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = CALC;
      a_d     = a;
      b_d     = b;
      acc_d   = '0;
      cnt_d   = '0;
      carry_d = ci;
      zacc_d  = 1'b1;
`ifdef AU_ADD_VZ_SERIAL_SAT_EN
      sat_d   = sat;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
`ifdef AU_ADD_VZ_SERIAL_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      s_q     <= s_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
`ifdef AU_ADD_VZ_SERIAL_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign s  = s_q;
  assign co = co_q;
  assign v  = v_q;
  assign z  = z_q;

endmodule

// File: tb/tb_au_add_vz_serial.sv
// Bench for au_add_vz_serial: four instances (DIGIT=1,2,4,8)
// run in lock-step against an arithmetic reference model.
module tb_au_add_vz_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a_in, b_in;
  logic       ci_in;
  logic       sat_in;
  logic [3:0] ir, ov, co_w, v_w, z_w;
  logic [7:0] s_w [4];

  int n_tests = 0;
  int n_fail  = 0;
  int lat [4];

  logic [7:0] e_s;
  logic       e_co, e_v, e_z;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    au_add_vz_serial #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .a         (a_in),
      .b         (b_in),
      .ci        (ci_in),
`ifdef AU_ADD_VZ_SERIAL_SAT_EN
      .sat       (sat_in),
`endif
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .s         (s_w[g]),
      .co        (co_w[g]),
      .v         (v_w[g]),
      .z         (z_w[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic st);
    int u, sa, sb, sg;
    u  = int'(a) + int'(b) + int'(c);
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
    sg = sa + sb + int'(c);
    e_s  = u[7:0];
    e_co = (u > 255);
    e_v  = (sg > 127) || (sg < -128);
`ifdef AU_ADD_VZ_SERIAL_SAT_EN
    if (st && e_v) e_s = a[7] ? 8'h80 : 8'h7F;
`else
    if (st) e_s = e_s;
`endif
    e_z  = (e_s == 8'h00);
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic st);
    int k;
    model(a, b, c, st);
    a_in = a; b_in = b; ci_in = c; sat_in = st;
    in_valid = 1'b1;
    k = 0;
    while (ir != 4'hF && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("accept_ready", 32'(ir), 32'hF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom);
    ci_in = 1'($urandom); sat_in = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int g = 0; g < 4; g++) lat[g] = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++)
        if (ov[g] && lat[g] == 0) lat[g] = k;
      if (ov == 4'hF) break;
    end
    chk("done_timeout", 32'(ov), 32'hF);
  endtask

  task automatic check_res();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("s[d%0d] a=%h b=%h", 1 << g, a_in, b_in),
          32'(s_w[g]), 32'(e_s));
      chk($sformatf("co[d%0d]", 1 << g), 32'(co_w[g]), 32'(e_co));
      chk($sformatf("v[d%0d]", 1 << g), 32'(v_w[g]), 32'(e_v));
      chk($sformatf("z[d%0d]", 1 << g), 32'(z_w[g]), 32'(e_z));
      chk($sformatf("lat[d%0d]", 1 << g), 32'(lat[g]), 32'(8 >> g));
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ov_drop", 32'(ov), 32'h0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic st);
    start(a, b, c, st);
    wait_done();
    check_res();
    release_out();
  endtask

  initial begin : main
    logic [7:0] cv [5];
    logic [7:0] hs;
    logic       any;
    cv[0] = 8'h00; cv[1] = 8'h01; cv[2] = 8'h7F;
    cv[3] = 8'h80; cv[4] = 8'hFF;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = 8'h00; b_in = 8'h00; ci_in = 1'b0; sat_in = 1'b0;
    @(posedge clk); #1;
    chk("rst_ov", 32'(ov), 32'h0);
    chk("rst_ir", 32'(ir), 32'hF);
    chk("rst_s", 32'(s_w[1]), 32'h0);
    chk("rst_flags", 32'({co_w, v_w, z_w}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);

    // backpressure, then accept a new op in the release cycle
    start(8'h55, 8'hAB, 1'b1, 1'b0);
    wait_done();
    check_res();
    hs = s_w[1];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_ov", 32'(ov), 32'hF);
      chk("bp_ir", 32'(ir), 32'h0);
      chk("bp_s", 32'(s_w[1]), 32'(hs));
      chk("bp_flags", 32'({co_w[1], v_w[1], z_w[1]}),
          32'({e_co, e_v, e_z}));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ir_release", 32'(ir), 32'hF);
    start(8'h40, 8'h40, 1'b0, 1'b0);
    chk("bp_next_busy", 32'(ov), 32'h0);
    wait_done();
    check_res();
    release_out();

    // reset during the second CALC cycle
    start(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ov", 32'(ov), 32'h0);
    chk("mid_rst_ir", 32'(ir), 32'hF);
    chk("mid_rst_s", 32'(s_w[1]), 32'h0);
    chk("mid_rst_flags", 32'({co_w, v_w, z_w}), 32'h0);
    any = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      any = any | (|ov);
    end
    chk("mid_rst_stale", 32'(any), 32'h0);

`ifdef AU_ADD_VZ_SERIAL_SAT_EN
    run_op(8'h7F, 8'h01, 1'b0, 1'b1);
    run_op(8'h80, 8'hFF, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int c = 0; c < 2; c++)
          run_op(cv[i], cv[j], 1'(c), 1'($urandom));

    for (int n = 0; n < 1200; n++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom),
             1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
